stage_fetch1: RTL and testbench

//  Second fetch stage. Tracks the icache requests issued by fetch0 in order and

---
 rtl/stage_fetch1.sv | 126 ++++++++++++
 tb/tb_stage_fetch1.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_fetch1.sv
// Second fetch stage: in-order buffer tracking icache requests from fetch0,
// capturing responses and presenting {pc, insn, fault} to decode.
module stage_fetch1 #(
   parameter int DEPTH = 2
) (
   input  logic        clk_core,
   input  logic        reset_n,
   input  logic        fe0_valid,
   input  logic [29:0] fe0_read_addr,
   output logic        fe1_stall,
   input  logic        icache_resp_valid,
   input  logic [31:0] icache_resp_data,
   input  logic        icache_resp_fault,
   output logic        fe1_valid,
   output logic [29:0] fe1_pc,
   output logic [31:0] fe1_insn,
   output logic        fe1_fault,
   input  logic        de_stall,
   input  logic        de_setpc,
   input  logic        csr_kill,
   input  logic        csr_setpc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [29:0]       pc_q   [DEPTH];
   logic [31:0]       insn_q [DEPTH];
   logic [DEPTH-1:0]  fault_q;
   logic [DEPTH-1:0]  filled_q;
   logic [PW-1:0]     head_q, head_d, fill_q, fill_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d, ufl_q, ufl_d, drop_q, drop_d;

   logic flush, resp_fill, resp_drop, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (int'(p) == DEPTH - 1) r = '0;
      else                      r = p + PW'(1);
      return r;
   endfunction

   assign flush     = de_setpc | csr_setpc | csr_kill;
   // ufl_q counts allocated entries still waiting for their response
   assign resp_fill = icache_resp_valid && (drop_q == '0) && (ufl_q != '0);
   assign resp_drop = icache_resp_valid && (drop_q != '0);

   assign fe1_valid = filled_q[head_q] & ~flush;
   assign fe1_pc    = pc_q[head_q];
   assign fe1_insn  = insn_q[head_q];
   assign fe1_fault = fault_q[head_q];
   assign pop       = fe1_valid & ~de_stall;

   // Registered state only, so fetch0 sees no combinational path back from fe0_valid
   assign fe1_stall = ({1'b0, count_q} + {1'b0, drop_q}) >= (CW + 1)'(DEPTH);

   always_comb begin
      head_d  = head_q;
      fill_d  = fill_q;
      tail_d  = tail_q;
      count_d = count_q;
      ufl_d   = ufl_q;
      drop_d  = drop_q;
      if (flush) begin
         head_d  = tail_q;
         fill_d  = tail_q;
         tail_d  = fe0_valid ? ptr_inc(tail_q) : tail_q;
         count_d = CW'(fe0_valid);
         ufl_d   = CW'(fe0_valid);
         drop_d  = drop_q + ufl_q - CW'(resp_fill | resp_drop);
      end else begin
         head_d  = pop       ? ptr_inc(head_q) : head_q;
         fill_d  = resp_fill ? ptr_inc(fill_q) : fill_q;
         tail_d  = fe0_valid ? ptr_inc(tail_q) : tail_q;
         count_d = count_q + CW'(fe0_valid) - CW'(pop);
         ufl_d   = ufl_q + CW'(fe0_valid) - CW'(resp_fill);
         drop_d  = drop_q - CW'(resp_drop);
      end
   end

   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         head_q   <= '0;
         fill_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         ufl_q    <= '0;
         drop_q   <= '0;
         filled_q <= '0;
         fault_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            insn_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         fill_q  <= fill_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ufl_q   <= ufl_d;
         drop_q  <= drop_d;
         // Later writes win: pop clear, fill set, alloc clear, then flush clears everything
         if (pop) filled_q[head_q] <= 1'b0;
         if (resp_fill) begin
            insn_q[fill_q]   <= icache_resp_data;
            fault_q[fill_q]  <= icache_resp_fault;
            filled_q[fill_q] <= 1'b1;
         end
         if (fe0_valid) begin
            pc_q[tail_q]     <= fe0_read_addr;
            filled_q[tail_q] <= 1'b0;
         end
         if (flush) filled_q <= '0;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_core) begin
      if (reset_n) begin
         assert (!(icache_resp_valid && drop_q == '0 && ufl_q == '0));
         assert (count_q <= CW'(DEPTH));
      end
   end
`endif

endmodule

// File: tb/tb_stage_fetch1.sv
// Randomised scoreboard bench for stage_fetch1: stimulus pushes expected
// instructions, a negedge monitor compares presentation, pops and stall.
module tb_stage_fetch1;

   localparam int DEPTH = 2;

   logic        clk_core = 1'b0;
   logic        reset_n;
   logic        fe0_valid;
   logic [29:0] fe0_read_addr;
   logic        fe1_stall;
   logic        icache_resp_valid;
   logic [31:0] icache_resp_data;
   logic        icache_resp_fault;
   logic        fe1_valid;
   logic [29:0] fe1_pc;
   logic [31:0] fe1_insn;
   logic        fe1_fault;
   logic        de_stall;
   logic        de_setpc;
   logic        csr_kill;
   logic        csr_setpc;

   stage_fetch1 #(.DEPTH(DEPTH)) dut (
      .clk_core          (clk_core),
      .reset_n           (reset_n),
      .fe0_valid         (fe0_valid),
      .fe0_read_addr     (fe0_read_addr),
      .fe1_stall         (fe1_stall),
      .icache_resp_valid (icache_resp_valid),
      .icache_resp_data  (icache_resp_data),
      .icache_resp_fault (icache_resp_fault),
      .fe1_valid         (fe1_valid),
      .fe1_pc            (fe1_pc),
      .fe1_insn          (fe1_insn),
      .fe1_fault         (fe1_fault),
      .de_stall          (de_stall),
      .de_setpc          (de_setpc),
      .csr_kill          (csr_kill),
      .csr_setpc         (csr_setpc)
   );

   always #5 clk_core = ~clk_core;

   typedef struct {
      logic [29:0] pc;
      logic [31:0] insn;
      logic        fault;
      int          id;
      int          born;
      logic        arrived;
   } ent_t;

   typedef struct {
      int          id;
      int          born;
      logic [31:0] insn;
      logic        fault;
   } req_t;

   ent_t exp_q[$];
   req_t icq[$];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int nid         = 0;
   int dead_out    = 0;
   bit mon_en      = 1'b0;
   bit cur_flush   = 1'b0;
   bit cur_resp    = 1'b0;
   int cur_resp_id = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, req);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, ".fe1_valid"}, 32'(fe1_valid), 32'd0);
      chk({tag, ".fe1_stall"}, 32'(fe1_stall), 32'd0);
      chk({tag, ".fe1_pc"},    32'(fe1_pc),    32'd0);
      chk({tag, ".fe1_insn"},  fe1_insn,       32'd0);
      chk({tag, ".fe1_fault"}, 32'(fe1_fault), 32'd0);
   endtask

   // Monitor: compare outputs against the model, then apply this cycle's events
   always @(negedge clk_core) begin : monitor
      int   live_old;
      int   idx;
      bit   ev;
      ent_t keep[$];
      if (mon_en) begin
         live_old = 0;
         foreach (exp_q[i]) if (exp_q[i].born < cyc) live_old++;
         chk("fe1_stall", 32'(fe1_stall), 32'((live_old + dead_out) >= DEPTH));

         ev = (exp_q.size() > 0) && exp_q[0].arrived && !cur_flush;
         chk("fe1_valid", 32'(fe1_valid), 32'(ev));
         if (ev && fe1_valid) begin
            chk("fe1_pc", 32'(fe1_pc), 32'(exp_q[0].pc));
            chk("fe1_fault", 32'(fe1_fault), 32'(exp_q[0].fault));
            if (!exp_q[0].fault) chk("fe1_insn", fe1_insn, exp_q[0].insn);
         end

         if (cur_resp) begin
            idx = -1;
            foreach (exp_q[i]) if (exp_q[i].id == cur_resp_id) idx = i;
            if (idx >= 0) exp_q[idx].arrived = 1'b1;
            else          dead_out--;
         end

         if (ev && !de_stall) void'(exp_q.pop_front());

         if (cur_flush) begin
            keep.delete();
            foreach (exp_q[i]) begin
               if (exp_q[i].born == cyc) keep.push_back(exp_q[i]);
               else if (!exp_q[i].arrived) dead_out++;
            end
            exp_q = keep;
         end
      end
   end

   task automatic drive_idle();
      fe0_valid         = 1'b0;
      fe0_read_addr     = '0;
      icache_resp_valid = 1'b0;
      icache_resp_data  = '0;
      icache_resp_fault = 1'b0;
      de_stall          = 1'b0;
      de_setpc          = 1'b0;
      csr_kill          = 1'b0;
      csr_setpc         = 1'b0;
      cur_flush         = 1'b0;
      cur_resp          = 1'b0;
   endtask

   task automatic run_phase(input int ncyc, input int p_flush, input int p_stall,
                            input int p_alloc, input int p_resp);
      req_t r;
      ent_t e;
      int   icq_before;
      bit   ok;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk_core);
         #1;
         cyc++;
         de_setpc  = 1'b0;
         csr_kill  = 1'b0;
         csr_setpc = 1'b0;
         if ($urandom_range(0, 99) < p_flush) begin
            case ($urandom_range(0, 2))
               0:       de_setpc  = 1'b1;
               1:       csr_kill  = 1'b1;
               default: csr_setpc = 1'b1;
            endcase
         end
         cur_flush = de_setpc | csr_setpc | csr_kill;
         de_stall  = ($urandom_range(0, 99) < p_stall);

         icq_before        = icq.size();
         icache_resp_valid = 1'b0;
         icache_resp_data  = $urandom;
         icache_resp_fault = 1'b0;
         cur_resp          = 1'b0;
         if (icq.size() > 0 && icq[0].born < cyc && $urandom_range(0, 99) < p_resp) begin
            r = icq.pop_front();
            icache_resp_valid = 1'b1;
            icache_resp_data  = r.insn;
            icache_resp_fault = r.fault;
            cur_resp          = 1'b1;
            cur_resp_id       = r.id;
         end

         // csr_setpc may override stall, but never beyond DEPTH requests in flight
         ok = !fe1_stall || (csr_setpc && icq_before < DEPTH);
         fe0_valid     = ok && ($urandom_range(0, 99) < p_alloc);
         fe0_read_addr = 30'($urandom);
         if (fe0_valid) begin
            e.pc      = fe0_read_addr;
            e.insn    = $urandom;
            e.fault   = ($urandom_range(0, 99) < 15);
            e.id      = nid;
            e.born    = cyc;
            e.arrived = 1'b0;
            exp_q.push_back(e);
            r.id    = nid;
            r.born  = cyc;
            r.insn  = e.insn;
            r.fault = e.fault;
            icq.push_back(r);
            nid++;
         end
         mon_en = 1'b1;
      end
   endtask

   task automatic mid_reset();
      @(posedge clk_core);
      #1;
      mon_en = 1'b0;
      drive_idle();
      #2;
      reset_n = 1'b0;
      #1;
      chk_outputs_zero("mid_reset");
      exp_q.delete();
      icq.delete();
      dead_out = 0;
      @(posedge clk_core);
      @(posedge clk_core);
      #3;
      reset_n = 1'b1;
   endtask

   initial begin
      drive_idle();
      reset_n = 1'b0;
      #2;
      chk_outputs_zero("por");
      @(posedge clk_core);
      @(posedge clk_core);
      #3;
      reset_n = 1'b1;

      run_phase(600, 5, 20, 70, 60);
      run_phase(500, 0, 90, 90, 80);
      mid_reset();
      run_phase(600, 15, 10, 80, 30);
      mid_reset();
      run_phase(600, 8, 40, 50, 50);
      run_phase(300, 30, 50, 90, 20);

      @(posedge clk_core);
      #1;
      mon_en = 1'b0;
      drive_idle();
      @(posedge clk_core);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
